// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types and constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_e;

  localparam int OVS     = 16;
  localparam int VOTE_LO = 7;
  localparam int VOTE_HI = 9;

  // Characters the display stage treats specially
  localparam logic [7:0] CR   = 8'h0D;
  localparam logic [7:0] DASH = 8'h2D;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - free-running divisor producing a one-clk oversample tick
module baud_tick_gen #(
  parameter int DIV = 651
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    tick_d = (cnt_q == LAST);
    cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 receiver, 16x oversampled with 3-sample majority vote
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       newdata,
  output logic       frame_err,
  output logic       busy,
  output logic       baud
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

  logic       rx_meta_q, rx_s_q;
  state_e     state_q, state_d;
  logic [3:0] samp_cnt_q, samp_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       v_lo_q, v_lo_d, v_mid_q, v_mid_d;
  logic [7:0] data_q, data_d;
  logic       newdata_q, newdata_d;
  logic       frame_err_q, frame_err_d;
  logic       busy_q, busy_d;
  logic [3:0] cur_tick;
  logic       vote;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .reset(reset),
    .tick (baud)
  );

  // The detection tick is tick 0; cur_tick is the index of the tick now arriving
  assign cur_tick = samp_cnt_q + 4'd1;
  assign vote     = majority3(v_lo_q, v_mid_q, rx_s_q);

  always_comb begin
    state_d     = state_q;
    samp_cnt_d  = samp_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    v_lo_d      = v_lo_q;
    v_mid_d     = v_mid_q;
    data_d      = data_q;
    newdata_d   = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = (state_q != IDLE);
    if (baud) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            samp_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = START;
          end
        end
        WAIT_IDLE: begin
          if (rx_s_q) state_d = IDLE;
        end
        default: begin
          samp_cnt_d = cur_tick;
          if (cur_tick == 4'(VOTE_LO))     v_lo_d  = rx_s_q;
          if (cur_tick == 4'(VOTE_LO + 1)) v_mid_d = rx_s_q;
          if (cur_tick == 4'(VOTE_HI)) begin
            case (state_q)
              START: state_d = vote ? IDLE : DATA;
              DATA: begin
                shift_d   = {vote, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = STOP;
              end
              STOP: begin
                // Leave mid-stop-bit so a following start edge is never missed
                if (vote) begin
                  data_d    = shift_q;
                  newdata_d = 1'b1;
                  state_d   = IDLE;
                end else begin
                  frame_err_d = 1'b1;
                  state_d     = WAIT_IDLE;
                end
              end
              default: state_d = IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      samp_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      v_lo_q      <= 1'b1;
      v_mid_q     <= 1'b1;
      data_q      <= '0;
      newdata_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      v_lo_q      <= v_lo_d;
      v_mid_q     <= v_mid_d;
      data_q      <= data_d;
      newdata_q   <= newdata_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign data      = data_q;
  assign newdata   = newdata_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb/tb_uart_rx_byte.sv - directed self-checking bench for uart_rx_byte
`timescale 1ns/1ps
module tb_uart_rx_byte;
  import uart_pkg::*;

  // Clock chosen so DIV = 8 at 9600 baud; bit time stays 104.1667 us
  localparam int  TB_CLK = 1_228_800;
  localparam int  TB_BAUD = 9600;
  localparam real HALF = 1.0e9 / TB_CLK / 2.0;
  localparam real BIT_NS = 1.0e9 / 9600.0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       newdata, frame_err, busy, baud;

  int  n_checks = 0;
  int  n_fail = 0;
  int  nd_cnt = 0;
  int  fe_cnt = 0;
  int  both_cnt = 0;
  logic [7:0] d_log [0:63];
  real t_log [0:63];

  uart_rx_byte #(.CLK_FREQ(TB_CLK), .BAUD(TB_BAUD), .OVERSAMPLE(16)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data(data),
    .newdata(newdata), .frame_err(frame_err), .busy(busy), .baud(baud)
  );

  always #(HALF) clk = ~clk;

  always @(negedge clk) begin
    if (newdata) begin
      if (nd_cnt < 64) begin
        d_log[nd_cnt] = data;
        t_log[nd_cnt] = $realtime;
      end
      nd_cnt = nd_cnt + 1;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (newdata && frame_err) both_cnt = both_cnt + 1;
  end

  task automatic send_byte(input logic [7:0] b, input real bit_ns, input logic stop_val);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_val;
    #(bit_ns);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    #1000;
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data); end
    n_checks++; if (newdata !== 1'b0) begin n_fail++; $display("FAIL reset_newdata: got %b want 0", newdata); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (baud !== 1'b0) begin n_fail++; $display("FAIL reset_baud: got %b want 0", baud); end
    @(negedge clk);
    reset = 1'b0;
    #(BIT_NS);
  endtask

  task automatic test_single;
    int n0, f0;
    n0 = nd_cnt; f0 = fe_cnt;
    send_byte(8'h41, BIT_NS, 1'b1);
    #(2.0 * BIT_NS);
    n_checks++; if (nd_cnt - n0 !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", nd_cnt - n0); end
    n_checks++; if (d_log[n0] !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h want 41", d_log[n0]); end
    n_checks++; if (fe_cnt - f0 !== 0) begin n_fail++; $display("FAIL single_fe: got %0d want 0", fe_cnt - f0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_back_to_back;
    int n0, f0;
    real dt;
    n0 = nd_cnt; f0 = fe_cnt;
    send_byte(CR, BIT_NS, 1'b1);
    send_byte(DASH, BIT_NS, 1'b1);
    #(2.0 * BIT_NS);
    n_checks++; if (nd_cnt - n0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", nd_cnt - n0); end
    n_checks++; if (d_log[n0] !== 8'h0D) begin n_fail++; $display("FAIL b2b_first: got %h want 0d", d_log[n0]); end
    n_checks++; if (d_log[n0+1] !== 8'h2D) begin n_fail++; $display("FAIL b2b_second: got %h want 2d", d_log[n0+1]); end
    dt = t_log[n0+1] - t_log[n0];
    n_checks++;
    if (dt < 10.0 * BIT_NS - BIT_NS / 8.0 || dt > 10.0 * BIT_NS + BIT_NS / 8.0) begin
      n_fail++; $display("FAIL b2b_spacing: got %0.1f ns want %0.1f ns", dt, 10.0 * BIT_NS);
    end
    n_checks++; if (fe_cnt - f0 !== 0) begin n_fail++; $display("FAIL b2b_fe: got %0d want 0", fe_cnt - f0); end
  endtask

  task automatic test_glitch;
    int n0, f0;
    n0 = nd_cnt; f0 = fe_cnt;
    rx = 1'b0;
    #20000;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b want 1", busy); end
    rx = 1'b1;
    #(BIT_NS - 20000.0);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low: got %b want 0", busy); end
    #(BIT_NS);
    n_checks++; if (nd_cnt - n0 !== 0) begin n_fail++; $display("FAIL glitch_newdata: got %0d want 0", nd_cnt - n0); end
    n_checks++; if (fe_cnt - f0 !== 0) begin n_fail++; $display("FAIL glitch_fe: got %0d want 0", fe_cnt - f0); end
  endtask

  task automatic test_frame_err;
    int n0, f0;
    n0 = nd_cnt; f0 = fe_cnt;
    send_byte(8'h55, BIT_NS, 1'b0);
    #2000000;
    n_checks++; if (fe_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d want 1", fe_cnt - f0); end
    n_checks++; if (nd_cnt - n0 !== 0) begin n_fail++; $display("FAIL ferr_newdata: got %0d want 0", nd_cnt - n0); end
    n_checks++; if (data !== 8'h2D) begin n_fail++; $display("FAIL ferr_data_hold: got %h want 2d", data); end
    rx = 1'b1;
    #(2.0 * BIT_NS);
    n0 = nd_cnt; f0 = fe_cnt;
    send_byte(8'h33, BIT_NS, 1'b1);
    #(2.0 * BIT_NS);
    n_checks++; if (nd_cnt - n0 !== 1) begin n_fail++; $display("FAIL ferr_recover_count: got %0d want 1", nd_cnt - n0); end
    n_checks++; if (data !== 8'h33) begin n_fail++; $display("FAIL ferr_recover_data: got %h want 33", data); end
    n_checks++; if (fe_cnt - f0 !== 0) begin n_fail++; $display("FAIL ferr_recover_fe: got %0d want 0", fe_cnt - f0); end
  endtask

  task automatic test_reset_midframe;
    logic [7:0] b;
    int n0;
    b = 8'hA5;
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = b[4];
    #(0.5 * BIT_NS);
    reset = 1'b1;
    #1;
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL midreset_data: got %h want 00", data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
    #49;
    reset = 1'b0;
    n0 = nd_cnt;
    #(0.5 * BIT_NS - 50.0);
    for (int i = 5; i < 8; i++) begin
      rx = b[i];
      #(BIT_NS);
    end
    rx = 1'b1;
    #(BIT_NS);
    n_checks++; if (nd_cnt - n0 !== 0) begin n_fail++; $display("FAIL midreset_no_byte: got %0d want 0", nd_cnt - n0); end
    n_checks++; if (data !== 8'h00) begin n_fail++; $display("FAIL midreset_data_after: got %h want 00", data); end
    // Trailing zero bits of the aborted frame look like a fresh start; let that drain
    #(12.0 * BIT_NS);
    send_byte(8'h5A, BIT_NS, 1'b1);
    #(2.0 * BIT_NS);
    n_checks++; if (data !== 8'h5A) begin n_fail++; $display("FAIL midreset_next: got %h want 5a", data); end
  endtask

  task automatic test_baud_tolerance(input real rate);
    int n0, f0;
    real bn;
    bn = 1.0e9 / rate;
    n0 = nd_cnt; f0 = fe_cnt;
    send_byte(8'hFF, bn, 1'b1);
    #(2.0 * bn);
    send_byte(8'h00, bn, 1'b1);
    #(2.0 * bn);
    n_checks++; if (nd_cnt - n0 !== 2) begin n_fail++; $display("FAIL tol_count @%0.0f: got %0d want 2", rate, nd_cnt - n0); end
    n_checks++; if (d_log[n0] !== 8'hFF) begin n_fail++; $display("FAIL tol_ff @%0.0f: got %h want ff", rate, d_log[n0]); end
    n_checks++; if (d_log[n0+1] !== 8'h00) begin n_fail++; $display("FAIL tol_00 @%0.0f: got %h want 00", rate, d_log[n0+1]); end
    n_checks++; if (fe_cnt - f0 !== 0) begin n_fail++; $display("FAIL tol_fe @%0.0f: got %0d want 0", rate, fe_cnt - f0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_baud_tolerance(9888.0);
    test_baud_tolerance(9312.0);
    n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL exclusive_pulses: got %0d overlaps want 0", both_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
